cla_logic_4: RTL and testbench

CLA_LOGIC_4 -- requirements
Module: cla_logic_4

---
 rtl/cla_pkg.sv | 16 +
 rtl/cla_gp_merge.sv | 14 +
 rtl/cla_logic_4.sv | 108 ++++++++++
 tb/tb_cla_logic_4.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared width constant and types for the 4-bit carry-lookahead group
package cla_pkg;

  // Number of bit positions handled by one lookahead group.
  localparam int CLA_WIDTH = 4;

  // Generate/propagate pair for a bit or a merged span of bits.
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Carries c1..c4 out of the group, LSB first.
  typedef logic [CLA_WIDTH-1:0] carry_t;

endpackage

// File: rtl/cla_gp_merge.sv
// rtl/cla_gp_merge.sv - merges a high and a low generate/propagate span into one
import cla_pkg::*;

module cla_gp_merge (
  input  gp_t hi,
  input  gp_t lo,
  output gp_t merged
);

  // The high span generates on its own, or passes through a carry generated below it.
  assign merged.g = hi.g | (hi.p & lo.g);
  assign merged.p = hi.p & lo.p;

endmodule

// File: rtl/cla_logic_4.sv
// rtl/cla_logic_4.sv - 4-bit lookahead group G/P/carries with registered copies; carries enabled by CLA_LOGIC_4_CARRY_EN
import cla_pkg::*;

module cla_logic_4 (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [CLA_WIDTH-1:0] i_g,
  input  logic [CLA_WIDTH-1:0] i_p,
  input  logic                 i_c,
  input  logic                 i_valid,
  output logic                 o_g,
  output logic                 o_p,
  output carry_t               o_c,
  output logic                 o_g_q,
  output logic                 o_p_q,
  output carry_t               o_c_q,
  output logic                 o_valid
);

  gp_t bit_32_hi;
  gp_t bit_32_lo;
  gp_t bit_10_hi;
  gp_t bit_10_lo;
  gp_t span_32;
  gp_t span_10;
  gp_t group;

  assign bit_32_hi = '{g: i_g[3], p: i_p[3]};
  assign bit_32_lo = '{g: i_g[2], p: i_p[2]};
  assign bit_10_hi = '{g: i_g[1], p: i_p[1]};
  assign bit_10_lo = '{g: i_g[0], p: i_p[0]};

  // Two-level merge tree: pairs (3,2) and (1,0) first, then the two spans.
  cla_gp_merge u_merge_32 (
    .hi     (bit_32_hi),
    .lo     (bit_32_lo),
    .merged (span_32)
  );

  cla_gp_merge u_merge_10 (
    .hi     (bit_10_hi),
    .lo     (bit_10_lo),
    .merged (span_10)
  );

  cla_gp_merge u_merge_top (
    .hi     (span_32),
    .lo     (span_10),
    .merged (group)
  );

  // Group outputs are pure functions of g/p; no reset or enable touches them.
  assign o_g = group.g;
  assign o_p = group.p;

`ifdef CLA_LOGIC_4_CARRY_EN
  carry_t carry;

  // Every carry is a flat sum of products from c0, so no carry waits on another.
  always_comb begin
    carry    = '0;
    carry[0] = i_g[0] | (i_p[0] & i_c);
    carry[1] = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_c);
    carry[2] = i_g[2] | (i_p[2] & i_g[1]) | (i_p[2] & i_p[1] & i_g[0])
             | (i_p[2] & i_p[1] & i_p[0] & i_c);
    carry[3] = group.g | (group.p & i_c);
  end

  assign o_c = carry;

  // Capture the carries alongside G/P when the inputs are qualified.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_c_q <= '0;
    end else if (i_valid) begin
      o_c_q <= carry;
    end
  end
`else
  logic unused_c;

  // Carry logic is absent in this build; the carry-in has no consumer.
  assign unused_c = i_c;
  assign o_c      = '0;
  assign o_c_q    = '0;
`endif

  // Registered G/P load only on qualified cycles; reset clears them asynchronously.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_g_q <= 1'b0;
      o_p_q <= 1'b0;
    end else if (i_valid) begin
      o_g_q <= group.g;
      o_p_q <= group.p;
    end
  end

  // The valid flag tracks i_valid every cycle so it marks exactly the capture cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
    end else begin
      o_valid <= i_valid;
    end
  end

endmodule

// File: tb/tb_cla_logic_4.sv
// tb/tb_cla_logic_4.sv - directed self-checking bench for cla_logic_4
module tb_cla_logic_4;

  logic       i_clk;
  logic       i_rst_n;
  logic [3:0] i_g;
  logic [3:0] i_p;
  logic       i_c;
  logic       i_valid;
  logic       o_g;
  logic       o_p;
  logic [3:0] o_c;
  logic       o_g_q;
  logic       o_p_q;
  logic [3:0] o_c_q;
  logic       o_valid;

  int pass_count;
  int check_count;

  cla_logic_4 dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_g     (i_g),
    .i_p     (i_p),
    .i_c     (i_c),
    .i_valid (i_valid),
    .o_g     (o_g),
    .o_p     (o_p),
    .o_c     (o_c),
    .o_g_q   (o_g_q),
    .o_p_q   (o_p_q),
    .o_c_q   (o_c_q),
    .o_valid (o_valid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_g     = 4'b1000;
    i_p     = 4'b0000;
    i_c     = 1'b0;
    i_valid = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    check_count++;
    if ({o_g_q, o_p_q, o_c_q, o_valid} !== 7'b0) begin
      $display("FAIL reset_regs: got g_q=%b p_q=%b c_q=%b valid=%b, want all 0", o_g_q, o_p_q, o_c_q, o_valid);
    end else pass_count++;
    check_count++;
    if (o_g !== 1'b1 || o_p !== 1'b0) begin
      $display("FAIL comb_in_reset: got G=%b P=%b, want G=1 P=0", o_g, o_p);
    end else pass_count++;
  endtask

  task automatic test_group_gp();
    logic [3:0] tg [10];
    logic [3:0] tp [10];
    logic       eg [10];
    logic       ep [10];
    tg = '{4'b0000, 4'b1000, 4'b0000, 4'b1111, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b0001, 4'b0010};
    tp = '{4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b1010, 4'b0000, 4'b0100};
    eg = '{1'b0,    1'b1,    1'b0,    1'b1,    1'b1,    1'b1,    1'b1,    1'b1,    1'b0,    1'b0};
    ep = '{1'b0,    1'b0,    1'b1,    1'b1,    1'b0,    1'b0,    1'b0,    1'b0,    1'b0,    1'b0};
    for (int i = 0; i < 10; i++) begin
      i_g = tg[i];
      i_p = tp[i];
      i_c = i[0];
      #1;
      check_count++;
      if (o_g !== eg[i] || o_p !== ep[i]) begin
        $display("FAIL group_gp[%0d] g=%b p=%b: got G=%b P=%b, want G=%b P=%b", i, tg[i], tp[i], o_g, o_p, eg[i], ep[i]);
      end else pass_count++;
    end
  endtask

  task automatic test_carry();
    logic [3:0] tg [5];
    logic [3:0] tp [5];
    logic       tc [5];
    logic [3:0] ec [5];
    tg = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010};
    tp = '{4'b0000, 4'b1111, 4'b1111, 4'b1110, 4'b0100};
    tc = '{1'b0,    1'b1,    1'b0,    1'b0,    1'b1};
`ifdef CLA_LOGIC_4_CARRY_EN
    ec = '{4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0110};
`else
    ec = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
`endif
    for (int i = 0; i < 5; i++) begin
      i_g = tg[i];
      i_p = tp[i];
      i_c = tc[i];
      #1;
      check_count++;
      if (o_c !== ec[i]) begin
        $display("FAIL carry[%0d] g=%b p=%b c=%b: got o_c=%b, want %b", i, tg[i], tp[i], tc[i], o_c, ec[i]);
      end else pass_count++;
    end
  endtask

  task automatic test_registers();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_valid = 1'b1;
    i_g     = 4'b1000;
    i_p     = 4'b0000;
    i_c     = 1'b0;
    @(posedge i_clk);
    #1;
    check_count++;
    if (o_g_q !== 1'b1 || o_p_q !== 1'b0 || o_valid !== 1'b1) begin
      $display("FAIL capture_g: got g_q=%b p_q=%b valid=%b, want 1 0 1", o_g_q, o_p_q, o_valid);
    end else pass_count++;
    @(negedge i_clk);
    i_valid = 1'b0;
    i_g     = 4'b0000;
    i_p     = 4'b1111;
    @(posedge i_clk);
    #1;
    check_count++;
    if (o_g_q !== 1'b1 || o_p_q !== 1'b0 || o_valid !== 1'b0) begin
      $display("FAIL hold: got g_q=%b p_q=%b valid=%b, want 1 0 0", o_g_q, o_p_q, o_valid);
    end else pass_count++;
    @(negedge i_clk);
    i_valid = 1'b1;
    i_c     = 1'b1;
    @(posedge i_clk);
    #1;
    check_count++;
`ifdef CLA_LOGIC_4_CARRY_EN
    if (o_g_q !== 1'b0 || o_p_q !== 1'b1 || o_c_q !== 4'b1111 || o_valid !== 1'b1) begin
      $display("FAIL capture_p: got g_q=%b p_q=%b c_q=%b valid=%b, want 0 1 1111 1", o_g_q, o_p_q, o_c_q, o_valid);
    end else pass_count++;
`else
    if (o_g_q !== 1'b0 || o_p_q !== 1'b1 || o_c_q !== 4'b0000 || o_valid !== 1'b1) begin
      $display("FAIL capture_p: got g_q=%b p_q=%b c_q=%b valid=%b, want 0 1 0000 1", o_g_q, o_p_q, o_c_q, o_valid);
    end else pass_count++;
`endif
  endtask

  task automatic test_reset_during_valid();
    @(negedge i_clk);
    i_valid = 1'b1;
    i_g     = 4'b1111;
    i_p     = 4'b1111;
    i_rst_n = 1'b0;
    #1;
    check_count++;
    if ({o_g_q, o_p_q, o_c_q, o_valid} !== 7'b0) begin
      $display("FAIL async_reset: got g_q=%b p_q=%b c_q=%b valid=%b, want all 0", o_g_q, o_p_q, o_c_q, o_valid);
    end else pass_count++;
    @(posedge i_clk);
    #1;
    check_count++;
    if ({o_g_q, o_p_q, o_valid} !== 3'b0) begin
      $display("FAIL discard_in_reset: got g_q=%b p_q=%b valid=%b, want 0 0 0", o_g_q, o_p_q, o_valid);
    end else pass_count++;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_valid = 1'b0;
    @(posedge i_clk);
    #1;
    check_count++;
    if ({o_g_q, o_p_q, o_valid} !== 3'b0) begin
      $display("FAIL no_capture_after_release: got g_q=%b p_q=%b valid=%b, want 0 0 0", o_g_q, o_p_q, o_valid);
    end else pass_count++;
    @(negedge i_clk);
    i_valid = 1'b1;
    @(posedge i_clk);
    #1;
    check_count++;
    if ({o_g_q, o_p_q, o_valid} !== 3'b111) begin
      $display("FAIL first_capture: got g_q=%b p_q=%b valid=%b, want 1 1 1", o_g_q, o_p_q, o_valid);
    end else pass_count++;
  endtask

  initial begin
    pass_count  = 0;
    check_count = 0;
    test_reset();
    test_group_gp();
    test_carry();
    test_registers();
    test_reset_during_valid();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
